// File: rtl/utf8_encoder_if.sv
// Handshake bundle for the streaming UTF-8 encoder: code-point input
// channel, byte output channel, error reporting and an FSM debug tap.
interface utf8_encoder_if #(
    parameter int ERR_CNT_W = 16
);
    // Input channel: code point offered by the source
    logic                 in_valid;
    logic                 in_ready;
    logic [20:0]          in_cp;
    logic                 in_last;

    // Output channel: one encoded byte per transfer
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;
    logic                 out_first;
    logic                 out_last;

    // Error reporting
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    // FSM state tap (0 = IDLE, 1 = EMIT)
    logic                 dbg_state;

    // Encoder side
    modport slave (
        input  in_valid, in_cp, in_last, out_ready,
        output in_ready, out_valid, out_data, out_first, out_last,
               err_pulse, err_count, dbg_state
    );

    // Source/sink side
    modport master (
        output in_valid, in_cp, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_first, out_last,
               err_pulse, err_count, dbg_state
    );
endinterface

// File: rtl/utf8_encoder.sv
// Streaming UTF-8 encoder. Accepts one Unicode code point per transfer and
// emits its UTF-8 byte sequence, one byte per output transfer, MSB-first.
//
// Handshake semantics (both channels): a beat transfers on a rising clock
// edge where valid & ready are both high. The producer holds valid and its
// payload stable until the transfer; ready may change freely. out_* are
// registered and held while out_valid & !out_ready. in_ready is
// combinational: high in IDLE, or while the final byte of the current code
// point is transferring, so consecutive code points stream with no bubble.
//
// Invalid code points (surrogates D800..DFFF, or above 10FFFF) raise a
// one-cycle err_pulse and bump a saturating counter; they are then either
// replaced by U+FFFD or dropped without producing any bytes.
module utf8_encoder #(
    parameter bit REPLACE_INVALID = 1'b1,
    parameter int ERR_CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    utf8_encoder_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t               r_state;
    logic [2:0]           r_rem;       // bytes of current cp not yet transferred, incl. the one on out_data
    logic [23:0]          r_tail;      // bytes still to be loaded, left-aligned
    logic                 r_last;      // current cp was accepted with in_last
    logic                 r_out_valid;
    logic [7:0]           r_out_data;
    logic                 r_out_first;
    logic                 r_out_last;
    logic                 r_err_pulse;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic                 w_invalid;
    logic                 w_out_xfer;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_emit;
    logic [20:0]          w_cp;
    logic [2:0]           w_len;
    logic [7:0]           w_lead;
    logic [23:0]          w_tail;

    // Classify the offered code point and pick what actually gets encoded
    assign w_invalid  = ((bus.in_cp >= 21'h00D800) && (bus.in_cp <= 21'h00DFFF)) ||
                        (bus.in_cp > 21'h10FFFF);
    assign w_cp       = w_invalid ? 21'h00FFFD : bus.in_cp;

    // Channel handshakes
    assign w_out_xfer = r_out_valid & bus.out_ready;
    assign w_in_ready = (r_state == IDLE) | (w_out_xfer & (r_rem == 3'd1));
    assign w_accept   = bus.in_valid & w_in_ready;
    // A dropped invalid cp is accepted but produces no bytes
    assign w_emit     = w_accept & (~w_invalid | REPLACE_INVALID);

    // Split the code point into lead byte and up to three continuation bytes
    always_comb begin
        w_len  = 3'd1;
        w_lead = 8'h00;
        w_tail = 24'h000000;
        if (w_cp < 21'h000080) begin
            w_len  = 3'd1;
            w_lead = {1'b0, w_cp[6:0]};
        end else if (w_cp < 21'h000800) begin
            w_len  = 3'd2;
            w_lead = {3'b110, w_cp[10:6]};
            w_tail = {2'b10, w_cp[5:0], 16'h0000};
        end else if (w_cp < 21'h010000) begin
            w_len  = 3'd3;
            w_lead = {4'b1110, w_cp[15:12]};
            w_tail = {2'b10, w_cp[11:6], 2'b10, w_cp[5:0], 8'h00};
        end else begin
            w_len  = 3'd4;
            w_lead = {5'b11110, w_cp[20:18]};
            w_tail = {2'b10, w_cp[17:12], 2'b10, w_cp[11:6], 2'b10, w_cp[5:0]};
        end
    end

    // Emit FSM: load lead byte on accept, shift continuation bytes on each transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rem       <= 3'd0;
            r_tail      <= 24'h000000;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_emit) begin
            // New code point: either from IDLE or chained onto the final byte
            r_state     <= EMIT;
            r_rem       <= w_len;
            r_tail      <= w_tail;
            r_last      <= bus.in_last;
            r_out_valid <= 1'b1;
            r_out_data  <= w_lead;
            r_out_first <= 1'b1;
            r_out_last  <= bus.in_last & (w_len == 3'd1);
        end else if (w_out_xfer) begin
            if (r_rem == 3'd1) begin
                // Final byte gone and nothing new to encode
                r_state     <= IDLE;
                r_rem       <= 3'd0;
                r_out_valid <= 1'b0;
                r_out_first <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                r_rem       <= r_rem - 3'd1;
                r_tail      <= {r_tail[15:0], 8'h00};
                r_out_data  <= r_tail[23:16];
                r_out_first <= 1'b0;
                r_out_last  <= r_last & (r_rem == 3'd2);
            end
        end
    end

    // Error pulse and saturating error counter, one step per accepted invalid cp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_accept & w_invalid;
            if (w_accept && w_invalid && (r_err_count != {ERR_CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_first = r_out_first;
    assign bus.out_last  = r_out_last;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_utf8_encoder.sv
// Bench for utf8_encoder: replacing instance (dut0) carries the main traffic,
// dropping instance (dut1) checks the no-replacement path. Expected bytes are
// queued at accept time; a negedge monitor pops and compares on every transfer.
module tb_utf8_encoder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    utf8_encoder_if #(.ERR_CNT_W(16)) bus0 ();
    utf8_encoder_if #(.ERR_CNT_W(16)) bus1 ();

    utf8_encoder #(.REPLACE_INVALID(1'b1), .ERR_CNT_W(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    utf8_encoder #(.REPLACE_INVALID(1'b0), .ERR_CNT_W(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] exp_q[$];          // {first, last, data}
    bit         rand_ready = 1'b0;
    bit         mon1_on    = 1'b0;
    int         pulse0 = 0;
    int         pulse1 = 0;
    int         cyc = 0;
    int         pop_cyc = 0;
    int         prev_pop_cyc = 0;
    int         accept_wait = 0;
    bit         prev_stall = 1'b0;
    logic [9:0] prev_word = '0;

    logic [20:0] t_cp[10];
    int          t_n[10];
    logic [31:0] t_b[10];

    // Clock/reset block helpers
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference encoder used for the random stream
    function automatic void ref_encode(input logic [20:0] cp, output int n, output logic [31:0] b);
        if (cp < 21'h80) begin
            n = 1; b = {1'b0, cp[6:0], 24'h0};
        end else if (cp < 21'h800) begin
            n = 2; b = {3'b110, cp[10:6], 2'b10, cp[5:0], 16'h0};
        end else if (cp < 21'h10000) begin
            n = 3; b = {4'b1110, cp[15:12], 2'b10, cp[11:6], 2'b10, cp[5:0], 8'h0};
        end else begin
            n = 4; b = {5'b11110, cp[20:18], 2'b10, cp[17:12], 2'b10, cp[11:6], 2'b10, cp[5:0]};
        end
    endfunction

    // Sink ready driver
    initial begin
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus0.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard monitor for dut0
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall) begin
                    check("hold_stable", {21'h0, bus0.out_valid, bus0.out_first, bus0.out_last, bus0.out_data},
                          {21'h0, 1'b1, prev_word});
                end
                if (bus0.out_valid && bus0.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL extra_byte: got %h expected no byte (cycle %0d)", bus0.out_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", {22'h0, bus0.out_first, bus0.out_last, bus0.out_data}, {22'h0, e});
                    end
                    prev_pop_cyc = pop_cyc;
                    pop_cyc      = cyc;
                end
                prev_stall = bus0.out_valid && !bus0.out_ready;
                prev_word  = {bus0.out_first, bus0.out_last, bus0.out_data};
                if (bus0.err_pulse) pulse0++;
                if (bus1.err_pulse) pulse1++;
                if (mon1_on) check("dut1_no_output", {31'h0, bus1.out_valid}, 32'h0);
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Driver: offer one cp to dut0 and queue its expected bytes at accept
    task automatic send(input logic [20:0] cp, input logic last, input int n,
                        input logic [31:0] bytes, input logic inv);
        bit ok;
        ok = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_cp    = cp;
        bus0.in_last  = last;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                ok = 1'b1;
                accept_wait = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            check("accept_timeout", 32'h0, 32'h1);
            bus0.in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == 0), (last && (i == n - 1)), bytes[31 - 8 * i -: 8]});
        end
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus0.in_cp    = 21'($urandom);
        bus0.in_last  = 1'($urandom_range(0, 1));
        check("err_pulse", {31'h0, bus0.err_pulse}, {31'h0, inv});
    endtask

    // Driver: offer one invalid cp to the dropping instance
    task automatic send1(input logic [20:0] cp, input logic last);
        bus1.in_valid = 1'b1;
        bus1.in_cp    = cp;
        bus1.in_last  = last;
        @(negedge clk);
        check("dut1_in_ready", {31'h0, bus1.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        check("dut1_err_pulse", {31'h0, bus1.err_pulse}, 32'h1);
    endtask

    // Wait until every queued byte is out and dut0 has gone idle
    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 8000; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !bus0.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'h0, ok}, 32'h1);
    endtask

    initial begin
        logic [20:0] cp;
        logic [31:0] b;
        int          n;

        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_cp = '0; bus0.in_last = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_cp = '0; bus1.in_last = 1'b0;

        t_cp[0] = 21'h0000E9; t_n[0] = 2; t_b[0] = 32'hC3A90000;
        t_cp[1] = 21'h0020AC; t_n[1] = 3; t_b[1] = 32'hE282AC00;
        t_cp[2] = 21'h01F600; t_n[2] = 4; t_b[2] = 32'hF09F9880;
        t_cp[3] = 21'h10FFFF; t_n[3] = 4; t_b[3] = 32'hF48FBFBF;
        t_cp[4] = 21'h00007F; t_n[4] = 1; t_b[4] = 32'h7F000000;
        t_cp[5] = 21'h000080; t_n[5] = 2; t_b[5] = 32'hC2800000;
        t_cp[6] = 21'h0007FF; t_n[6] = 2; t_b[6] = 32'hDFBF0000;
        t_cp[7] = 21'h000800; t_n[7] = 3; t_b[7] = 32'hE0A08000;
        t_cp[8] = 21'h00FFFF; t_n[8] = 3; t_b[8] = 32'hEFBFBF00;
        t_cp[9] = 21'h010000; t_n[9] = 4; t_b[9] = 32'hF0908080;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, bus0.out_valid}, 32'h0);
        check("rst_out_data",  {24'h0, bus0.out_data},  32'h0);
        check("rst_first_last_err", {29'h0, bus0.out_first, bus0.out_last, bus0.err_pulse}, 32'h0);
        check("rst_err_count", {16'h0, bus0.err_count}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'h0, bus0.in_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Single ASCII byte, then back-to-back ASCII
        send(21'h41, 1'b1, 1, 32'h41000000, 1'b0);
        check("in_ready_first", accept_wait, 0);
        drain("drain_ascii");
        send(21'h41, 1'b0, 1, 32'h41000000, 1'b0);
        check("in_ready_b2b_a", accept_wait, 0);
        send(21'h42, 1'b1, 1, 32'h42000000, 1'b0);
        check("in_ready_b2b_b", accept_wait, 0);
        drain("drain_b2b");
        check("b2b_consecutive", pop_cyc - prev_pop_cyc, 1);

        // Multi-byte vectors and length boundaries, alternating in_last
        for (int i = 0; i < 10; i++) begin
            send(t_cp[i], 1'(i % 2), t_n[i], t_b[i], 1'b0);
        end
        drain("drain_vectors");

        // Invalid code points on the replacing instance
        send(21'h00D800, 1'b0, 3, 32'hEFBFBD00, 1'b1);
        send(21'h00DFFF, 1'b0, 3, 32'hEFBFBD00, 1'b1);
        send(21'h110000, 1'b1, 3, 32'hEFBFBD00, 1'b1);
        drain("drain_invalid");
        check("err_count_replace", {16'h0, bus0.err_count}, 32'd3);
        check("err_pulses_replace", pulse0, 3);

        // Invalid code points on the dropping instance
        mon1_on = 1'b1;
        send1(21'h00D800, 1'b0);
        send1(21'h00DFFF, 1'b0);
        send1(21'h110000, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        mon1_on = 1'b0;
        check("err_count_drop", {16'h0, bus1.err_count}, 32'd3);
        check("err_pulses_drop", pulse1, 3);
        check("dut1_idle", {31'h0, bus1.dbg_state}, 32'h0);

        // Random stream under 50% backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: cp = 21'($urandom_range(0, 'h7F));
                1: cp = 21'($urandom_range('h80, 'h7FF));
                2: begin
                    cp = 21'($urandom_range('h800, 'hFFFF));
                    if (cp >= 21'hD800 && cp <= 21'hDFFF) cp = cp - 21'h1000;
                end
                default: cp = 21'($urandom_range('h10000, 'h10FFFF));
            endcase
            ref_encode(cp, n, b);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(cp, 1'($urandom_range(0, 1)), n, b, 1'b0);
        end
        drain("drain_random");
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a 4-byte sequence
        send(21'h01F600, 1'b1, 4, 32'hF09F9880, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_remaining", exp_q.size(), 2);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'h0, bus0.out_valid}, 32'h0);
        check("mid_rst_err_count", {16'h0, bus0.err_count}, 32'h0);
        check("mid_rst_state", {31'h0, bus0.dbg_state}, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'h0, bus0.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        send(21'h41, 1'b1, 1, 32'h41000000, 1'b0);
        drain("drain_post_reset");
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_quiet", {31'h0, bus0.out_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
